// File: rtl/crc_serial_feeder.sv
`default_nettype none
// ============================================================================
// Module      : crc_serial_feeder
// Description : Serialises a CRC job for a bit-serial CRC engine. On start it
//               shifts the captured polynomial and then the initial value out
//               MSB first, clears the engine for one cycle, then streams the
//               message bytes MSB first through a small byte buffer and a bit
//               shifter until the byte tagged "last" has been sent.
// Ports       : clk, rst_n (async, active-low)
//               cfg_start, cfg_poly[WIDTH], cfg_init[WIDTH]  - frame setup
//               in_data[8], in_valid, in_last, in_ready      - byte stream
//               poly_bit/poly_load, init_bit/init_load       - serial loads
//               crc_data/crc_en, crc_rst_n                   - engine feed
//               busy, frame_done                             - status
// Build macro : CRC_FEEDER_FIFO_EN - when defined the byte buffer is a
//               4-entry FIFO; otherwise it is a single holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_serial_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [WIDTH-1:0] cfg_poly,
  input  logic [WIDTH-1:0] cfg_init,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             poly_bit,
  output logic             poly_load,
  output logic             init_bit,
  output logic             init_load,
  output logic             crc_data,
  output logic             crc_en,
  output logic             crc_rst_n,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD_POLY = 3'd1;
  localparam logic [2:0] S_LOAD_INIT = 3'd2;
  localparam logic [2:0] S_CLEAR     = 3'd3;
  localparam logic [2:0] S_STREAM    = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(WIDTH - 1);

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] poly_q, poly_d;
  logic [WIDTH-1:0] init_q, init_d;
  logic             last_acc_q, last_acc_d;

  // Shifter: sh_rem_q is the number of bits still to be sent from sh_q[7].
  logic [7:0]       sh_q, sh_d;
  logic [3:0]       sh_rem_q, sh_rem_d;
  logic             sh_last_q, sh_last_d;

  // Byte buffer common view
  logic             push, pop, buf_clr;
  logic             buf_empty, buf_full;
  logic [7:0]       head_data;
  logic             head_last;

  logic             emit_en, emit_bit, frame_end;

  assign push    = in_valid & in_ready;
  assign buf_clr = (state_q == S_IDLE);

  // --------------------------------------------------------------------------
  // Byte buffer
  // --------------------------------------------------------------------------
`ifdef CRC_FEEDER_FIFO_EN
  logic [7:0] fifo_data_q [4];
  logic       fifo_last_q [4];
  logic [1:0] rd_ptr_q, wr_ptr_q;
  logic [2:0] count_q;

  // Payload storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= in_data;
      fifo_last_q[wr_ptr_q] <= in_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else if (buf_clr) begin
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  assign buf_empty = (count_q == 3'd0);
  assign buf_full  = (count_q == 3'd4);
  assign head_data = fifo_data_q[rd_ptr_q];
  assign head_last = fifo_last_q[rd_ptr_q];
`else
  logic [7:0] hold_data_q;
  logic       hold_last_q;
  logic       hold_vld_q;

  // push only happens while empty and pop only while full, so they never
  // coincide in this single-entry buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data_q <= 8'd0;
      hold_last_q <= 1'b0;
      hold_vld_q  <= 1'b0;
    end else if (buf_clr) begin
      hold_vld_q  <= 1'b0;
    end else begin
      if (pop) hold_vld_q <= 1'b0;
      if (push) begin
        hold_vld_q  <= 1'b1;
        hold_data_q <= in_data;
        hold_last_q <= in_last;
      end
    end
  end

  assign buf_empty = ~hold_vld_q;
  assign buf_full  = hold_vld_q;
  assign head_data = hold_data_q;
  assign head_last = hold_last_q;
`endif

  // --------------------------------------------------------------------------
  // Bit shifter. When idle, the first bit of a byte is taken straight from the
  // buffer head so a newly buffered byte appears on crc_data the cycle after
  // it is accepted; the remaining 7 bits are then shifted out. During the last
  // bit of a byte the next full byte is pulled in so bytes run back to back.
  // --------------------------------------------------------------------------
  always_comb begin
    sh_d      = sh_q;
    sh_rem_d  = sh_rem_q;
    sh_last_d = sh_last_q;
    pop       = 1'b0;
    emit_en   = 1'b0;
    emit_bit  = 1'b0;
    frame_end = 1'b0;
    if (state_q == S_STREAM) begin
      if (sh_rem_q != 4'd0) begin
        emit_en  = 1'b1;
        emit_bit = sh_q[7];
        if (sh_rem_q == 4'd1) begin
          if (sh_last_q) begin
            frame_end = 1'b1;
            sh_rem_d  = 4'd0;
            sh_d      = 8'd0;
          end else if (!buf_empty) begin
            sh_d      = head_data;
            sh_rem_d  = 4'd8;
            sh_last_d = head_last;
            pop       = 1'b1;
          end else begin
            sh_rem_d  = 4'd0;
            sh_d      = 8'd0;
          end
        end else begin
          sh_d     = {sh_q[6:0], 1'b0};
          sh_rem_d = sh_rem_q - 4'd1;
        end
      end else if (!buf_empty) begin
        emit_en   = 1'b1;
        emit_bit  = head_data[7];
        sh_d      = {head_data[6:0], 1'b0};
        sh_rem_d  = 4'd7;
        sh_last_d = head_last;
        pop       = 1'b1;
      end
    end else if (state_q == S_IDLE) begin
      sh_d      = 8'd0;
      sh_rem_d  = 4'd0;
      sh_last_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    poly_d     = poly_q;
    init_d     = init_q;
    last_acc_d = last_acc_q;
    case (state_q)
      S_IDLE: begin
        last_acc_d = 1'b0;
        cnt_d      = '0;
        if (cfg_start) begin
          poly_d  = cfg_poly;
          init_d  = cfg_init;
          state_d = S_LOAD_POLY;
        end
      end
      S_LOAD_POLY: begin
        poly_d = poly_q << 1;
        if (cnt_q == C_CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_LOAD_INIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOAD_INIT: begin
        init_d = init_q << 1;
        if (cnt_q == C_CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_CLEAR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CLEAR: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (push && in_last) last_acc_d = 1'b1;
        if (frame_end)       state_d    = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      poly_q     <= '0;
      init_q     <= '0;
      last_acc_q <= 1'b0;
      sh_q       <= 8'd0;
      sh_rem_q   <= 4'd0;
      sh_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      poly_q     <= poly_d;
      init_q     <= init_d;
      last_acc_q <= last_acc_d;
      sh_q       <= sh_d;
      sh_rem_q   <= sh_rem_d;
      sh_last_q  <= sh_last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all derived from registered state so reset takes effect at once.
  // --------------------------------------------------------------------------
  assign poly_load  = (state_q == S_LOAD_POLY);
  assign poly_bit   = poly_load & poly_q[WIDTH-1];
  assign init_load  = (state_q == S_LOAD_INIT);
  assign init_bit   = init_load & init_q[WIDTH-1];
  assign crc_rst_n  = (state_q != S_CLEAR);
  assign crc_en     = emit_en;
  assign crc_data   = emit_en & emit_bit;
  assign in_ready   = (state_q == S_STREAM) & ~buf_full & ~last_acc_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_crc_serial_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_serial_feeder
// Description : Self-checking bench for crc_serial_feeder. A table of frames
//               (poly, init, bytes, expected serial stream) plus hand-written
//               sequences for mid-frame reset and buffer back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_serial_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_start;
  logic [7:0] cfg_poly, cfg_init;
  logic [7:0] in_data;
  logic       in_valid, in_last, in_ready;
  logic       poly_bit, poly_load, init_bit, init_load;
  logic       crc_data, crc_en, crc_rst_n, busy, frame_done;

  crc_serial_feeder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .cfg_poly(cfg_poly), .cfg_init(cfg_init),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .poly_bit(poly_bit), .poly_load(poly_load),
    .init_bit(init_bit), .init_load(init_load),
    .crc_data(crc_data), .crc_en(crc_en), .crc_rst_n(crc_rst_n),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Observation of serial outputs, sampled on the falling edge.
  int          cyc = 0;
  logic [7:0]  poly_col, init_col;
  logic [31:0] data_col;
  int          poly_n, init_n, data_n, clr_n, done_n, viol_n;
  int          first_en, last_en;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (poly_load) begin poly_col = {poly_col[6:0], poly_bit}; poly_n++; end
    if (init_load) begin init_col = {init_col[6:0], init_bit}; init_n++; end
    if (!crc_rst_n) clr_n++;
    if (crc_en) begin
      data_col = {data_col[30:0], crc_data};
      if (data_n == 0) first_en = cyc;
      last_en = cyc;
      data_n++;
    end
    if (frame_done) done_n++;
    if ((poly_load && init_load) || (!poly_load && poly_bit) ||
        (!init_load && init_bit) || (!crc_en && crc_data)) viol_n++;
  end

  task automatic clear_mon();
    poly_col = 0; init_col = 0; data_col = 0;
    poly_n = 0; init_n = 0; data_n = 0; clr_n = 0; done_n = 0; viol_n = 0;
    first_en = 0; last_en = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  poly;
    logic [7:0]  init;
    int          nb;
    logic [23:0] dat;     // byte 0 in the top byte
    int          gap;     // cycles with in_valid low after byte 0
    logic [31:0] exp_bits;
    int          exp_stall;
    bit          poke;    // pulse cfg_start while busy
  } vec_t;

  vec_t vecs [5];

  task automatic wait_ready(input string name);
    int t = 0;
    while (!in_ready && t < 80) begin @(negedge clk); t++; end
    if (t >= 80) chk({name, "_ready_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!frame_done && t < 120) begin @(negedge clk); t++; end
    if (t >= 120) chk({name, "_done_timeout"}, 0, 1);
  endtask

  task automatic start_frame(input logic [7:0] p, input logic [7:0] i);
    @(negedge clk);
    clear_mon();
    cfg_poly = p; cfg_init = i; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int acc = 0;
    string nm;
    nm = $sformatf("v%0d", idx);
    start_frame(v.poly, v.init);
    if (v.poke) begin
      repeat (10) @(negedge clk);
      cfg_poly = 8'h11; cfg_init = 8'h22; cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
    end
    for (int b = 0; b < v.nb; b++) begin
      in_data = v.dat[23-8*b -: 8]; in_last = (b == v.nb - 1); in_valid = 1'b1;
      wait_ready(nm);
      if (b == 0) acc = cyc;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      if (b == 0) repeat (v.gap) @(negedge clk);
    end
    if (v.poke) begin
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
    end
    wait_done(nm);
    repeat (2) @(negedge clk);
    chk({nm, "_poly"},   poly_col, v.poly);
    chk({nm, "_poly_n"}, poly_n, 8);
    chk({nm, "_init"},   init_col, v.init);
    chk({nm, "_init_n"}, init_n, 8);
    chk({nm, "_clr_n"},  clr_n, 1);
    chk({nm, "_bits_n"}, data_n, 8 * v.nb);
    chk({nm, "_bits"},   data_col, v.exp_bits);
    chk({nm, "_stall"},  last_en - first_en + 1 - data_n, v.exp_stall);
    chk({nm, "_latency"}, first_en, acc + 1);
    chk({nm, "_done_n"}, done_n, 1);
    chk({nm, "_busy"},   busy, 0);
    chk({nm, "_viol"},   viol_n, 0);
    repeat (4) @(negedge clk);
    chk({nm, "_idle"},   busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    logic [3:0] exp_pat;
    int         cnt;
    int         t;

    vecs[0] = '{8'hCC, 8'hAA, 1, 24'hF00000,  0, 32'h000000F0, 0, 1'b0};
    vecs[1] = '{8'h07, 8'h00, 2, 24'hA53C00,  0, 32'h0000A53C, 0, 1'b0};
    vecs[2] = '{8'h1D, 8'hFF, 2, 24'h817E00, 12, 32'h0000817E, 5, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 3, 24'h123456,  0, 32'h00123456, 0, 1'b0};
    vecs[4] = '{8'hCC, 8'hAA, 1, 24'hF00000,  0, 32'h000000F0, 0, 1'b1};

    rst_n = 1'b0; cfg_start = 0; cfg_poly = 0; cfg_init = 0;
    in_data = 0; in_valid = 0; in_last = 0;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_crc_en", crc_en, 0);
    chk("rst_crc_rst_n", crc_rst_n, 1);
    chk("rst_loads", {poly_load, init_load, frame_done}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_frame(vecs[i], i);

    // Reset while the 4th data bit is on the wire.
    start_frame(8'h07, 8'h00);
    in_data = 8'hF0; in_last = 1'b1; in_valid = 1'b1;
    cnt = 0; t = 0;
    while (cnt < 4 && t < 100) begin
      @(negedge clk); t++;
      if (crc_en) cnt++;
      if (in_ready) begin end
    end
    chk("mid_rst_reached", cnt, 4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_crc_en", {crc_en, crc_data}, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_crc_rst_n", crc_rst_n, 1);
    chk("mid_rst_other", {poly_load, poly_bit, init_load, init_bit, frame_done}, 0);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("mid_rst_no_done", done_n, 0);
    chk("mid_rst_idle", busy, 0);

    // Back-pressure: offer one byte per cycle for four cycles.
    start_frame(8'h07, 8'h00);
    in_data = 8'h10; in_last = 1'b0; in_valid = 1'b1;
    wait_ready("bp");
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h10 + 8'(i);
      pat[i] = in_ready;
      @(negedge clk);
    end
    in_data = 8'h99; in_last = 1'b1;
    wait_ready("bp_last");
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    wait_done("bp");
    repeat (2) @(negedge clk);
`ifdef CRC_FEEDER_FIFO_EN
    exp_pat = 4'b1111;
    chk("bp_bits_n", data_n, 40);
    chk("bp_bits", data_col, 32'h11121399);
`else
    exp_pat = 4'b0101;  // bit i = cycle i
    chk("bp_bits_n", data_n, 24);
    chk("bp_bits", data_col, 32'h00101299);
`endif
    chk("bp_ready_pattern", pat, exp_pat);
    chk("bp_done_n", done_n, 1);
    chk("bp_viol", viol_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
